// File: rtl/prog_loader.sv
// prog_loader: receives a MAGIC/length-prefixed byte image, writes it into instruction memory and holds the CPU in reset until the image is accepted.
// Optional trailing XOR checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader #(
  parameter int         ADDR_W      = 10,
  parameter logic [7:0] MAGIC       = 8'hA5,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);
  localparam int          CNT_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE, S_ERR
  } state_t;

  state_t              state, state_next;
  logic [15:0]         len;
  logic [15:0]         len_full;
  logic [1:0]          byte_idx;
  logic [23:0]         word_buf;
  logic [ADDR_W-1:0]   word_idx;
  logic                last_q;
  logic [CNT_W-1:0]    idle_cnt;
  logic                magic_hit;
  logic                timed_out;
  logic                write_last;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_reset  = 1'b1;
    magic_hit  = rx_valid && (rx_data == MAGIC);
    timed_out  = (idle_cnt == CNT_W'(TIMEOUT_CYC));
    // The pulse of the final word is the cycle that leaves DATA
    write_last = imem_we && last_q;
    len_full   = {rx_data, len[7:0]};
    case (state)
      S_IDLE: if (magic_hit) state_next = S_LEN_LO;
      S_LEN_LO: begin
        busy = 1'b1;
        if (rx_valid)       state_next = S_LEN_HI;
        else if (timed_out) state_next = S_ERR;
      end
      S_LEN_HI: begin
        busy = 1'b1;
        if (rx_valid) begin
          if (len_full == 16'd0 || {1'b0, len_full} > MAX_WORDS) state_next = S_ERR;
          else                                                  state_next = S_DATA;
        end else if (timed_out) begin
          state_next = S_ERR;
        end
      end
      S_DATA: begin
        busy = 1'b1;
        if (write_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          if (rx_valid) state_next = (rx_data == csum) ? S_DONE : S_ERR;
          else          state_next = S_CSUM;
`else
          state_next = S_DONE;
`endif
        end else if (!rx_valid && timed_out) begin
          state_next = S_ERR;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CSUM: begin
        busy = 1'b1;
        if (rx_valid)       state_next = (rx_data == csum) ? S_DONE : S_ERR;
        else if (timed_out) state_next = S_ERR;
      end
`endif
      S_DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
        if (magic_hit) state_next = S_LEN_LO;
      end
      S_ERR: begin
        error = 1'b1;
        if (magic_hit) state_next = S_LEN_LO;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      len          <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      word_idx     <= '0;
      last_q       <= 1'b0;
      idle_cnt     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (!busy || rx_valid || state_next != state) idle_cnt <= '0;
      else                                          idle_cnt <= idle_cnt + 1'b1;
      // A new image starts: forget everything about the previous one
      if (state_next == S_LEN_LO && state != S_LEN_LO) begin
        words_loaded <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum         <= '0;
`endif
      end
      if (state == S_LEN_LO && rx_valid) len[7:0] <= rx_data;
      if (state == S_LEN_HI && rx_valid) begin
        len[15:8] <= rx_data;
        word_idx  <= '0;
        byte_idx  <= '0;
      end
      if (state == S_DATA && rx_valid && !write_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
        csum <= csum ^ rx_data;
`endif
        byte_idx <= byte_idx + 1'b1;
        case (byte_idx)
          2'd0: word_buf[7:0]   <= rx_data;
          2'd1: word_buf[15:8]  <= rx_data;
          2'd2: word_buf[23:16] <= rx_data;
          2'd3: begin
            imem_we      <= 1'b1;
            imem_addr    <= word_idx;
            imem_wdata   <= {rx_data, word_buf};
            word_idx     <= word_idx + 1'b1;
            words_loaded <= words_loaded + 1'b1;
            last_q       <= (17'(words_loaded) + 17'd1) == {1'b0, len};
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning instruction-memory word-address width (depth 2**ADDR_W words).
REQ-002 The block SHALL have parameter MAGIC, default 8'hA5, meaning the start-of-image byte.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1000000, meaning the maximum idle cycles allowed between bytes mid-image.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, meaning the synchronous, active-high reset.
REQ-006 The block SHALL have port rx_valid, input, 1, meaning a one-cycle strobe that rx_data holds a received byte.
REQ-007 The block SHALL have port rx_data, input, 8, meaning the received byte.
REQ-008 The block SHALL have port imem_we, output, 1, meaning the instruction-memory write strobe.
REQ-009 The block SHALL have port imem_addr, output, ADDR_W, meaning the instruction-memory word address.
REQ-010 The block SHALL have port imem_wdata, output, 32, meaning the instruction-memory write data.
REQ-011 The block SHALL have port cpu_reset, output, 1, meaning the hold-in-reset signal driven to the CPU core.
REQ-012 The block SHALL have ports busy, done and error, output, 1 each, meaning image in progress, image accepted and image rejected.
REQ-013 The block SHALL have port words_loaded, output, ADDR_W+1, meaning the count of words written for the current image.

Function
REQ-014 The block SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE and ERR.
REQ-015 In IDLE, rx_valid with rx_data==MAGIC SHALL move to LEN_LO, and all other bytes SHALL be ignored.
REQ-016 LEN_LO and LEN_HI SHALL capture a 16-bit little-endian word count N, one byte per rx_valid.
REQ-017 On the LEN_HI byte, N==0 or N>2**ADDR_W SHALL move to ERR; otherwise the block SHALL clear the word index and byte index and move to DATA.
REQ-018 DATA SHALL assemble each word little-endian: the first byte goes to bits [7:0] and the fourth byte to bits [31:24].
REQ-019 The cycle after the fourth byte's rx_valid, the block SHALL drive imem_we=1 for exactly one cycle, with imem_addr=word index and imem_wdata=the assembled word.
REQ-020 The word index and words_loaded SHALL increment on each write.
REQ-021 After write N, the block SHALL move to CSUM when CHECKSUM_EN is defined, and to DONE otherwise.
REQ-022 An rx_valid in the same cycle as an imem_we pulse SHALL be accepted without loss; the input rate is at most one byte per cycle.
REQ-023 imem_we SHALL be 0 in every state except the write-pulse cycle in DATA.
REQ-024 cpu_reset SHALL be 1 in every state except DONE.
REQ-025 done SHALL be 1 only in DONE, error SHALL be 1 only in ERR, and busy SHALL be 1 in LEN_LO, LEN_HI, DATA and CSUM.
REQ-026 In DONE and ERR, a MAGIC byte SHALL restart the sequence at LEN_LO, reasserting cpu_reset and clearing words_loaded, done and error on the transition.
REQ-027 In LEN_LO, LEN_HI, DATA and CSUM, the idle counter SHALL clear on each rx_valid and on state entry.
REQ-028 The idle counter reaching TIMEOUT_CYC SHALL move to ERR; words already written are not rolled back.
REQ-029 A MAGIC-valued byte received while busy SHALL be treated as data.

Reset
REQ-030 On reset=1 at a clock edge, the block SHALL enter IDLE and drive cpu_reset=1, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0 and words_loaded=0.
REQ-031 On reset, the block SHALL clear the length, byte index, checksum and idle counter.
REQ-032 Reset during any state, including a write-pulse cycle, SHALL abort the image with no further writes.

Configuration
REQ-033 With macro PROG_LOADER_CHECKSUM_EN defined, the block SHALL keep a running XOR of all data bytes, reset on MAGIC acceptance.
REQ-034 With PROG_LOADER_CHECKSUM_EN defined, the one byte received in CSUM SHALL move to DONE if it equals the running XOR and to ERR otherwise.
REQ-035 With PROG_LOADER_CHECKSUM_EN undefined, CSUM and the XOR logic SHALL be absent and the block SHALL move from DATA to DONE directly.

Verification
REQ-036 Send A5 02 00 13 00 00 00 93 00 10 00 -> writes addr0=0x00000013 and addr1=0x00100093, then DONE, cpu_reset=0 and words_loaded=2.
REQ-037 Send 00 FF A5 01 00 then 4 bytes -> the leading 00 FF are ignored and one write occurs at addr0.
REQ-038 Send A5 00 00, and A5 01 04 with ADDR_W=10 -> ERR, error=1, cpu_reset=1, with no writes.
REQ-039 Send A5 02 00 followed by 3 bytes, then hold idle for TIMEOUT_CYC cycles (set to 16 in the bench) -> ERR with words_loaded=0.
REQ-040 With CHECKSUM_EN, send A5 01 00 11 22 33 44 then 44 -> DONE; send the same image with trailing 45 -> ERR; then send A5 01 00 plus 4 bytes plus a correct checksum -> DONE again.
REQ-041 Assert reset on the write-pulse cycle of word 1 of a 4-word image -> next cycle IDLE with all outputs at reset values and no later imem_we.
